// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port RAM.
// Turns req/gnt/ack transactions into mutually exclusive str/ld strobes and
// returns read data to the port that owns the transaction.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_str,
  output logic                  ram_ld,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;   // port granted most recently
  logic                  port_q, port_d;   // owner of the transaction in flight
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  str_q, str_d;
  logic                  ld_q, ld_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Next-state: arbitration in idle, strobe retire in issue, data return in capture
  always_comb begin
    logic sel;
    logic sel_we;
    sel      = 1'b0;
    sel_we   = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    addr_d   = addr_q;
    din_d    = din_q;
    str_d    = str_q;
    ld_d     = ld_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time gets the grant
          sel     = (req0 && req1) ? ~last_q : req1;
          sel_we  = sel ? we1 : we0;
          port_d  = sel;
          last_d  = sel;
          addr_d  = sel ? addr1 : addr0;
          din_d   = sel ? wdata1 : wdata0;
          str_d   = sel_we;
          ld_d    = ~sel_we;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          state_d = StIssue;
        end
      end
      StIssue: begin
        str_d = 1'b0;
        ld_d  = 1'b0;
        if (str_q) begin
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = StIdle;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (port_q) rdata1_d = ram_data_out;
        else        rdata0_d = ram_data_out;
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      str_q    <= 1'b0;
      ld_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      str_q    <= str_d;
      ld_q     <= ld_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_address = addr_q;
  assign ram_data_in = din_q;
  assign ram_str     = str_q;
  assign ram_ld      = ld_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, transaction-level reference
// model (pending requests, round-robin pointer, memory image), directed and
// random transactions.
module tb_ram_port_arbiter;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [19:0] wdata;
  } req_t;

  logic        clk, rst;
  logic        req0, we0, gnt0, ack0;
  logic [11:0] addr0;
  logic [19:0] wdata0, rdata0;
  logic        req1, we1, gnt1, ack1;
  logic [11:0] addr1;
  logic [19:0] wdata1, rdata1;
  logic [11:0] ram_address;
  logic [19:0] ram_data_in, ram_data_out;
  logic        ram_str, ram_ld;
  logic        mem_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  req_t        pend [2];
  bit          pv [2];
  int          last_port;
  logic [19:0] exp_mem [4096];
  logic [19:0] exp_rd [2];
  int          order [$];
  int          gnt_cyc;

  logic [19:0] ram_mem [4096];

  ram_port_arbiter #(.DATA_WIDTH(20), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_str(ram_str), .ram_ld(ram_ld), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_str) ram_mem[ram_address] <= ram_data_in;
      if (ram_ld)  ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Protocol invariants every cycle
  always @(negedge clk) begin
    check_eq("str_and_ld", 32'(ram_str & ram_ld), 32'd0);
    check_eq("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
    check_eq("ack_overlap", 32'(ack0 & ack1), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req0   = pv[0];
    we0    = pend[0].we;
    addr0  = pend[0].addr;
    wdata0 = pend[0].wdata;
    req1   = pv[1];
    we1    = pend[1].we;
    addr1  = pend[1].addr;
    wdata1 = pend[1].wdata;
  endtask

  task automatic set_req(input int p, input logic we, input logic [11:0] a, input logic [19:0] d);
    pend[p].we    = we;
    pend[p].addr  = a;
    pend[p].wdata = d;
    pv[p]         = 1'b1;
  endtask

  // Run one transaction from the current pending set; returns in its ack cycle
  task automatic service();
    int   w;
    req_t t;
    drive_reqs();
    if (pv[0] && pv[1]) w = (last_port == 0) ? 1 : 0;
    else                w = pv[0] ? 0 : 1;
    t = pend[w];
    step();
    check_eq("gnt", {30'd0, gnt1, gnt0}, (w == 0) ? 32'd1 : 32'd2);
    check_eq("str", 32'(ram_str), 32'(t.we));
    check_eq("ld", 32'(ram_ld), 32'(!t.we));
    check_eq("ram_address", 32'(ram_address), 32'(t.addr));
    if (t.we) check_eq("ram_data_in", 32'(ram_data_in), 32'(t.wdata));
    check_eq("ack_in_gnt", {30'd0, ack1, ack0}, 32'd0);
    gnt_cyc = cyc;
    order.push_back(w);
    pv[w]     = 1'b0;
    last_port = w;
    drive_reqs();
    step();
    check_eq("gnt_after", {30'd0, gnt1, gnt0}, 32'd0);
    check_eq("strobes_off", {30'd0, ram_str, ram_ld}, 32'd0);
    if (t.we) begin
      exp_mem[t.addr] = t.wdata;
    end else begin
      check_eq("ack_early", {30'd0, ack1, ack0}, 32'd0);
      step();
      exp_rd[w] = exp_mem[t.addr];
    end
    check_eq("ack", {30'd0, ack1, ack0}, (w == 0) ? 32'd1 : 32'd2);
    check_eq("rdata0", 32'(rdata0), 32'(exp_rd[0]));
    check_eq("rdata1", 32'(rdata1), 32'(exp_rd[1]));
  endtask

  function automatic logic [11:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 8) return 12'hFFF;
    if (r == 9) return 12'h000;
    return 12'(r) + 12'h0A0;
  endfunction

  initial begin
    int g_prev;
    rst     = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 4096; i++) exp_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    pend[0] = '{1'b0, 12'd0, 20'd0};
    pend[1] = '{1'b0, 12'd0, 20'd0};
    last_port = 1;
    drive_reqs();
    step();
    step();
    mem_clr = 1'b0;
    check_eq("rst_outs", {24'd0, gnt0, gnt1, ack0, ack1, ram_str, ram_ld, 2'b00}, 32'd0);
    check_eq("rst_rdata0", 32'(rdata0), 32'd0);
    check_eq("rst_rdata1", 32'(rdata1), 32'd0);
    check_eq("rst_addr", 32'(ram_address), 32'd0);
    check_eq("rst_din", 32'(ram_data_in), 32'd0);
    rst = 1'b0;
    step();

    // Write then read back on the other port
    set_req(0, 1'b1, 12'h0A5, 20'h12345);
    service();
    set_req(1, 1'b0, 12'h0A5, 20'h0);
    service();
    check_eq("t1_rdata1", 32'(rdata1), 32'h12345);
    check_eq("t1_rdata0", 32'(rdata0), 32'h0);

    // Both requesting, reissued after each ack: must alternate
    order.delete();
    set_req(0, 1'b1, 12'h010, 20'hAAAAA);
    set_req(1, 1'b1, 12'h011, 20'h55555);
    for (int k = 0; k < 4; k++) begin
      service();
      if (order[k] == 0) set_req(0, 1'b0, 12'h011, 20'h0);
      else               set_req(1, 1'b0, 12'h010, 20'h0);
    end
    check_eq("rr0", 32'(order[0]), 32'd0);
    check_eq("rr1", 32'(order[1]), 32'd1);
    check_eq("rr2", 32'(order[2]), 32'd0);
    check_eq("rr3", 32'(order[3]), 32'd1);
    while (pv[0] || pv[1]) service();

    // Address extremes
    set_req(1, 1'b1, 12'hFFF, 20'hFFFFF);
    service();
    set_req(0, 1'b1, 12'h000, 20'h00001);
    service();
    set_req(0, 1'b0, 12'hFFF, 20'h0);
    service();
    check_eq("ext_rdata0", 32'(rdata0), 32'hFFFFF);

    // Back-to-back reads on port 0: 3-cycle period
    set_req(0, 1'b0, 12'h000, 20'h0);
    service();
    g_prev = gnt_cyc;
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b0, (k == 0) ? 12'h0A5 : 12'hFFF, 20'h0);
      service();
      check_eq("rd_period", 32'(gnt_cyc - g_prev), 32'd3);
      g_prev = gnt_cyc;
    end

    // Reset during the issue cycle of a read
    set_req(1, 1'b0, 12'h0A5, 20'h0);
    drive_reqs();
    step();
    check_eq("mid_gnt1", 32'(gnt1), 32'd1);
    pv[1] = 1'b0;
    drive_reqs();
    rst = 1'b1;
    step();
    check_eq("mid_outs", {24'd0, gnt0, gnt1, ack0, ack1, ram_str, ram_ld, 2'b00}, 32'd0);
    check_eq("mid_rdata0", 32'(rdata0), 32'd0);
    check_eq("mid_rdata1", 32'(rdata1), 32'd0);
    check_eq("mid_addr", 32'(ram_address), 32'd0);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_port = 1;
    step();
    check_eq("mid_noack", {30'd0, ack1, ack0}, 32'd0);
    check_eq("mid_ld", 32'(ram_ld), 32'd0);
    set_req(0, 1'b1, 12'h0B0, 20'h0BEEF);
    set_req(1, 1'b1, 12'h0B1, 20'h0CAFE);
    service();
    check_eq("post_rst_winner", 32'(order[order.size()-1]), 32'd0);
    while (pv[0] || pv[1]) service();

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom_range(0, 1) == 1))
          set_req(p, 1'($urandom_range(0, 1)), pick_addr(), 20'($urandom));
      end
      if (!pv[0] && !pv[1])
        set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), 20'($urandom));
      service();
    end
    while (pv[0] || pv[1]) service();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 4096x20 RAM.
- Converts simple req/gnt/ack transactions from two masters (e.g. fetch unit = port 0, load/store unit = port 1) into the RAM's mutually exclusive str/ld strobes.
- Returns read data to the owning port and guarantees str and ld are never asserted together.

Parameters:
- DATA_WIDTH, 20, RAM word width.
- ADDR_WIDTH, 12, RAM address width (4096 words).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request.
- we0  input  1  port 0 operation: 1=write, 0=read.
- addr0  input  ADDR_WIDTH  port 0 address.
- wdata0  input  DATA_WIDTH  port 0 write data.
- gnt0  output  1  port 0 grant pulse; request captured.
- ack0  output  1  port 0 completion pulse.
- rdata0  output  DATA_WIDTH  port 0 read data; valid while ack0=1 on a read.
- req1, we1, addr1, wdata1, gnt1, ack1, rdata1  same as port 0, for port 1.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data_in  output  DATA_WIDTH  to RAM data_in.
- ram_str  output  1  to RAM str (write).
- ram_ld  output  1  to RAM ld (read).
- ram_data_out  input  DATA_WIDTH  from RAM data_out (registered in RAM, 1-cycle latency after ld).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- All outputs are registered.
- Reset values:
  - Every output 0; rdata0/rdata1 = 0.
  - State IDLE.
  - Last-grant pointer = 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, CAPTURE.
- IDLE:
  - Samples req0/req1 at each edge.
  - One requester: grant it.
  - Both requesting: grant the port not equal to the last-grant pointer.
  - Neither: stay in IDLE.
  - On grant edge: latch port index, we, addr, wdata into ram_address/ram_data_in. Set ram_str=we, ram_ld=!we. Set gntN=1 for exactly one cycle. Update pointer. Go to ISSUE.
- ISSUE (1 cycle):
  - Strobe is high; the RAM performs the access at the closing edge.
  - At that edge, strobes clear.
  - Write: ackN=1 for one cycle; go to IDLE.
  - Read: go to CAPTURE.
- CAPTURE (1 cycle):
  - ram_data_out is valid.
  - At the closing edge: rdataN <= ram_data_out, ackN=1 for one cycle, go to IDLE.
- Latency from grant edge:
  - Write: ack 1 cycle after gnt.
  - Read: ack 2 cycles after gnt.
  - Next grant can occur at the edge ending the ack cycle.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Deassert req by the edge that ends the gnt cycle, unless issuing a new request.
  - Inputs are ignored outside IDLE.
- Data outputs:
  - rdataN holds its last value until the next read completes on that port.
  - A write never modifies rdataN.
- ram_address and ram_data_in hold the last captured values when idle.
- Invariants:
  - ram_str & ram_ld is never 1.
  - At most one of gnt0/gnt1 and one of ack0/ack1 is high in any cycle.
  - Each gnt is followed by exactly one ack on the same port.
- Reset mid-operation: transaction abandoned, no ack issued, strobes low from the reset edge, pointer returns to 1.

Test Plan:
- Reset, then port 0 writes 0x12345 to 0x0A5 -> gnt0 cycle 1, ram_str=1/ram_ld=0 in cycle 1, ack0 cycle 2. A later port 1 read of 0x0A5 -> ack1 two cycles after gnt1 with rdata1=0x12345; rdata0 unchanged at 0.
- req0 and req1 asserted together and held (reissued after each ack) for 4 grants -> grants in order 0,1,0,1; no overlapping gnt/ack; ram_str&ram_ld never 1.
- Port 1 writes 0xFFFFF to 0xFFF, port 0 writes 0x00001 to 0x000, port 0 reads 0xFFF -> rdata0=0xFFFFF, ram_address=0xFFF during the read, no wrap or corruption at address extremes.
- Port 0 issues back-to-back reads with req held -> each ack0 is followed by gnt0 no earlier than the edge ending the ack cycle; 3-cycle read period confirmed.
- rst asserted during ISSUE of a read -> no ack, ram_ld=0 on the next cycle, all outputs 0. A subsequent simultaneous request is granted to port 0.
